instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 103 ++++++++++
 tb/tb_instr_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int FETCH_DEPTH = 2;
  localparam logic [31:0] HALT_ENCODING = 32'h0100_0000;
  localparam logic [31:0] HALT_MASK = 32'h0FFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  typedef enum logic {RUN, HALTED} fetch_state_t;

  function automatic logic is_halt(input logic [31:0] w);
    return (w & HALT_MASK) == HALT_ENCODING;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry registered FIFO of {pc, word}; slot 0 is always the head.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   occupancy
);
  fetch_entry_t [FETCH_DEPTH-1:0] slot;
  logic [1:0] cnt;
  logic       do_pop;

  assign do_pop = pop && (cnt != 2'd0);

  // Upstream credit accounting guarantees push never lands on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
      cnt  <= 2'd0;
    end else if (clear) begin
      cnt <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          slot[cnt[0]] <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot[0] <= slot[1];
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) slot[0] <= din;
          else begin
            slot[0] <= slot[1];
            slot[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head      = slot[0];
  assign occupancy = cnt;
endmodule

// File: rtl/instr_fetch.sv
// ARM32 fetch stage: PC, imem credit/outstanding tracking, redirect drops.
// Optional HALT detection is enabled with FETCH_HALT_DETECT_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        halted
);
  logic [31:0]  fetch_pc;
  logic [1:0]   outstanding, drop_cnt, occupancy, out_next;
  logic [2:0]   credit_use;
  fetch_entry_t head, push_entry;
  logic         halt_st, halt_pop, br, pop, push, clear, fire, rsp;

`ifdef FETCH_HALT_DETECT_EN
  fetch_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    halt_pop   = 1'b0;
    if (state == RUN && pop && is_halt(head.word)) begin
      halt_pop   = 1'b1;
      state_next = HALTED;
    end
  end

  assign halt_st = (state == HALTED);
`else
  assign halt_pop = 1'b0;
  assign halt_st  = 1'b0;
`endif

  assign br          = branch_taken && !halt_st;
  assign instr_valid = (occupancy != 2'd0) && !halt_st;
  assign pop         = instr_valid && instr_ready && !br;

  // The slot freed by this cycle's pop is already available as credit.
  assign credit_use = {1'b0, occupancy} - {2'b00, pop} + {1'b0, outstanding};
  assign imem_req   = !rst && !halt_st && !br && (credit_use < 3'd2);
  assign imem_addr  = fetch_pc;
  assign fire       = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol violation; ignore it.
  assign rsp      = imem_rvalid && (outstanding != 2'd0);
  assign out_next = outstanding + {1'b0, fire} - {1'b0, rsp};
  assign push     = rsp && (drop_cnt == 2'd0) && !br && !halt_pop && !halt_st;
  assign clear    = br || halt_pop;

  // With no drops pending, the returning word is the oldest live request.
  assign push_entry = '{pc: fetch_pc - {28'd0, outstanding, 2'b00}, word: imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC & ~32'h3;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= out_next;
      if (br) begin
        fetch_pc <= branch_target & ~32'h3;
        drop_cnt <= out_next;
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (halt_pop) drop_cnt <= out_next;
        else if (rsp && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .din       (push_entry),
    .head      (head),
    .occupancy (occupancy)
  );

  assign instr    = head.word;
  assign instr_pc = head.pc;
  assign halted   = halt_st;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order imem model with variable
// latency/grant, directed scenarios plus a randomized stream scoreboard.
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, branch_target = '0, instr, instr_pc;
  logic        branch_taken = 1'b0, instr_valid, instr_ready = 1'b0, halted;

  int vectors = 0, miscompares = 0;
  int cyc = 0, lat_min = 1, lat_max = 1, gnt_mode = 0;
  bit halt_word = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t pend[$];

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_word && a == 32'h8) return 32'h0100_0000;
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  // Instruction memory: records grants, answers in order after >= lat_min cycles.
  always @(negedge clk) begin
    if (imem_req && imem_gnt) begin
      mreq_t r;
      r.due  = cyc + $urandom_range(lat_max, lat_min);
      r.addr = imem_addr;
      pend.push_back(r);
    end
  end

  always @(posedge clk) begin
    #2;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    case (gnt_mode)
      0:       imem_gnt = 1'b1;
      1:       imem_gnt = 1'($urandom_range(1, 0));
      default: imem_gnt = 1'b0;
    endcase
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; branch_taken = 1'b0; instr_ready = 1'b0;
    gnt_mode = 0; lat_min = 1; lat_max = 1; halt_word = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n >= 2 && pend.size() == 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", imem_req); end
    vectors++; if (imem_addr !== RST_PC) begin miscompares++; $display("FAIL reset_addr got %h want %h", imem_addr, RST_PC); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    vectors++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h/%h want 0/0", instr, instr_pc); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; rst = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      a = RST_PC + 32'(4 * i);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        miscompares++; $display("FAIL seq_req c%0d got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, a);
      end
      vectors++;
      if (instr_valid !== (i >= 2)) begin
        miscompares++; $display("FAIL seq_valid c%0d got %b want %b", i, instr_valid, (i >= 2));
      end
      if (i >= 2) begin
        a = RST_PC + 32'(4 * (i - 2));
        vectors++;
        if (instr_pc !== a || instr !== mem_word(a)) begin
          miscompares++; $display("FAIL seq_instr c%0d got %h/%h want %h/%h", i, instr_pc, instr, a, mem_word(a));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int g = 0, r = 0, p = 0;
    bit rdy, popn;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1; rst = 1'b0;
      rdy = (i >= 6 && i < 11) ? 1'b0 : 1'($urandom_range(3, 0) != 0);
      instr_ready = rdy;
      @(negedge clk);
      vectors++;
      if (instr_valid !== (r > p)) begin
        miscompares++; $display("FAIL bp_valid c%0d got %b want %b", i, instr_valid, (r > p));
      end
      popn = (r > p) && rdy;
      vectors++;
      if (imem_req !== ((g - p - int'(popn)) < 2)) begin
        miscompares++; $display("FAIL bp_req c%0d got %b want %b", i, imem_req, ((g - p - int'(popn)) < 2));
      end
      if (instr_valid && instr_ready) begin
        vectors++;
        if (instr_pc !== RST_PC + 32'(4 * p) || instr !== mem_word(RST_PC + 32'(4 * p))) begin
          miscompares++; $display("FAIL bp_order c%0d got %h/%h want pc %h", i, instr_pc, instr, RST_PC + 32'(4 * p));
        end
        p++;
      end
      if (imem_req && imem_gnt) begin
        vectors++;
        if (imem_addr !== RST_PC + 32'(4 * g)) begin
          miscompares++; $display("FAIL bp_addr c%0d got %h want %h", i, imem_addr, RST_PC + 32'(4 * g));
        end
        g++;
      end
      if (imem_rvalid) r++;
    end
  endtask

  task automatic test_branch_redirect();
    logic [31:0] t, tw;
    do_reset();
    t  = $urandom;
    tw = t & ~32'h3;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; rst = 1'b0; instr_ready = 1'b1;
      branch_taken = (i == 3); branch_target = t;
      @(negedge clk);
      case (i)
        3: begin
          vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL br_req_in_branch got %b want 0", imem_req); end
        end
        4: begin
          vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL br_flush got valid %b want 0", instr_valid); end
          vectors++; if (imem_req !== 1'b1 || imem_addr !== tw) begin miscompares++; $display("FAIL br_target_req got %b/%h want 1/%h", imem_req, imem_addr, tw); end
        end
        5: begin
          vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL br_b2_valid got %b want 0", instr_valid); end
        end
        6: begin
          vectors++; if (instr_valid !== 1'b1 || instr_pc !== tw || instr !== mem_word(tw)) begin miscompares++; $display("FAIL br_target_instr got %b %h/%h want 1 %h/%h", instr_valid, instr_pc, instr, tw, mem_word(tw)); end
        end
        7: begin
          vectors++; if (instr_pc !== tw + 32'd4) begin miscompares++; $display("FAIL br_next_instr got %h want %h", instr_pc, tw + 32'd4); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_branch_drop();
    bit seen_v = 1'b0, seen_g = 1'b0;
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; rst = 1'b0; instr_ready = 1'b1;
      branch_taken = (i == 2); branch_target = 32'h0000_0103;
      @(negedge clk);
      if (i == 2) begin
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL drop_req_in_branch got %b want 0", imem_req); end
      end else if (i > 2) begin
        if (!seen_g && imem_req && imem_gnt) begin
          seen_g = 1'b1;
          vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL drop_first_addr got %h want 00000100", imem_addr); end
        end
        if (!seen_v && instr_valid) begin
          seen_v = 1'b1;
          vectors++; if (instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin miscompares++; $display("FAIL drop_first_instr got %h/%h want 00000100/%h", instr_pc, instr, mem_word(32'h100)); end
        end
      end
    end
    vectors++; if (!seen_v) begin miscompares++; $display("FAIL drop_timeout got no valid want valid within 20 cycles"); end
  endtask

  task automatic test_halt();
    do_reset();
    halt_word = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1; rst = 1'b0; instr_ready = 1'b1;
      branch_taken = (i == 8); branch_target = 32'h40;
      @(negedge clk);
`ifdef FETCH_HALT_DETECT_EN
      vectors++; if (halted !== (i >= 5)) begin miscompares++; $display("FAIL halt_flag c%0d got %b want %b", i, halted, (i >= 5)); end
      if (i >= 5) begin
        vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_stopped c%0d got req=%b valid=%b want 0/0", i, imem_req, instr_valid); end
      end
`else
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_flag c%0d got %b want 0", i, halted); end
      if (i == 5) begin
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC) begin miscompares++; $display("FAIL halt_pass_next got %b/%h want 1/0000000c", instr_valid, instr_pc); end
      end
      if (i == 9) begin
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin miscompares++; $display("FAIL halt_pass_branch got %b/%h want 1/00000040", imem_req, imem_addr); end
      end
`endif
      if (i == 4) begin
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== 32'h0100_0000) begin miscompares++; $display("FAIL halt_word got %b %h/%h want 1 00000008/01000000", instr_valid, instr_pc, instr); end
      end
    end
  endtask

  task automatic test_rst_midflight();
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rst = (i == 1); gnt_mode = (i == 1) ? 2 : 0; instr_ready = 1'b1;
      if (i == 2) begin lat_min = 1; lat_max = 1; end
      @(negedge clk);
      case (i)
        0: begin vectors++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin miscompares++; $display("FAIL rst_pre_req got %b/%h want 1/%h", imem_req, imem_addr, RST_PC); end end
        1: begin vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_in_reset got %b/%b want 0/0", imem_req, instr_valid); end end
        2: begin vectors++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_restart got %b/%h/%b want 1/%h/0", imem_req, imem_addr, instr_valid, RST_PC); end end
        3: begin vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_stale got valid %b want 0", instr_valid); end end
        4: begin vectors++; if (instr_valid !== 1'b1 || instr_pc !== RST_PC || instr !== mem_word(RST_PC)) begin miscompares++; $display("FAIL rst_first got %b %h/%h want 1 %h/%h", instr_valid, instr_pc, instr, RST_PC, mem_word(RST_PC)); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_random();
    logic [31:0] next_addr, exp_pc;
    int pops = 0;
    do_reset();
    gnt_mode = 1; lat_min = 1; lat_max = 3;
    next_addr = RST_PC; exp_pc = RST_PC;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1; rst = 1'b0;
      instr_ready   = 1'($urandom_range(1, 0));
      branch_taken  = (i > 20) && ($urandom_range(15, 0) == 0);
      branch_target = $urandom;
      @(negedge clk);
      if (branch_taken) begin
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rnd_branch_req c%0d got %b want 0", i, imem_req); end
        next_addr = branch_target & ~32'h3;
        exp_pc    = branch_target & ~32'h3;
      end else begin
        if (imem_req && imem_gnt) begin
          vectors++; if (imem_addr !== next_addr) begin miscompares++; $display("FAIL rnd_addr c%0d got %h want %h", i, imem_addr, next_addr); end
          next_addr += 32'd4;
        end
        if (instr_valid && instr_ready) begin
          vectors++; if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin miscompares++; $display("FAIL rnd_instr c%0d got %h/%h want %h/%h", i, instr_pc, instr, exp_pc, mem_word(exp_pc)); end
          exp_pc += 32'd4;
          pops++;
        end
      end
    end
    vectors++; if (pops < 20) begin miscompares++; $display("FAIL rnd_progress got %0d pops want >= 20", pops); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_redirect();
    test_branch_drop();
    test_halt();
    test_rst_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
